// File: rtl/dispatch_allocator.sv
// -----------------------------------------------------------------------------
// dispatch_allocator
//
// Two-wide in-order dispatch stage. Each cycle it looks at up to two decoded
// instructions (slot 0 older than slot 1). Each instruction is steered to one
// of ALU_CNT ALU reservation slots, the branch unit or the load/store unit. An
// instruction is accepted only when its target unit is available. Dispatched
// fields are registered toward the unit, and register-file lock updates (mw_*)
// are produced for destinations that get written.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   rdy                   global enable; low freezes every register and output
//   in_valid/pc/op/...    two incoming instruction slots, index 0 is older
//   in_accept             combinational; slot consumed at this clock edge
//   alu_busy / alu_*      per ALU slot busy input and registered dispatch fields,
//                         packed with slot i at [i*W +: W]
//   br_busy  / br_*       branch unit busy input and registered dispatch fields
//   ls_busy  / ls_*       load/store unit busy input and registered fields
//   mw_en/addr/tag        registered lock updates for the register state
//
// Unit tags: ALU i = i+1, branch = ALU_CNT+1, load/store = ALU_CNT+2.
// Tag 0 means unlocked.
// -----------------------------------------------------------------------------
module dispatch_allocator #(
    parameter int ALU_CNT = 2,
    parameter int TAG_W   = 4,
    parameter int WORD_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,

    input  logic [1:0]                    in_valid,
    input  logic [1:0][WORD_W-1:0]        in_pc,
    input  logic [1:0][7:0]               in_op,
    input  logic [1:0]                    in_en_ry,
    input  logic [1:0]                    in_en_w,
    input  logic [1:0][TAG_W-1:0]         in_tagx,
    input  logic [1:0][TAG_W-1:0]         in_tagy,
    input  logic [1:0][WORD_W-1:0]        in_datax,
    input  logic [1:0][WORD_W-1:0]        in_datay,
    input  logic [1:0][4:0]               in_waddr,
    output logic [1:0]                    in_accept,

    input  logic [ALU_CNT-1:0]            alu_busy,
    output logic [ALU_CNT-1:0]            alu_en,
    output logic [ALU_CNT*WORD_W-1:0]     alu_pc,
    output logic [ALU_CNT*WORD_W-1:0]     alu_datax,
    output logic [ALU_CNT*WORD_W-1:0]     alu_datay,
    output logic [ALU_CNT*4-1:0]          alu_op,
    output logic [ALU_CNT*TAG_W-1:0]      alu_tagx,
    output logic [ALU_CNT*TAG_W-1:0]      alu_tagy,
    output logic [ALU_CNT*TAG_W-1:0]      alu_tagw,
    output logic [ALU_CNT*5-1:0]          alu_waddr,

    input  logic                          br_busy,
    output logic                          br_en,
    output logic [WORD_W-1:0]             br_pc,
    output logic [WORD_W-1:0]             br_datax,
    output logic [WORD_W-1:0]             br_datay,
    output logic [3:0]                    br_op,
    output logic [TAG_W-1:0]              br_tagx,
    output logic [TAG_W-1:0]              br_tagy,
    output logic [TAG_W-1:0]              br_tagw,
    output logic [4:0]                    br_waddr,

    input  logic                          ls_busy,
    output logic                          ls_en,
    output logic [WORD_W-1:0]             ls_pc,
    output logic [WORD_W-1:0]             ls_datax,
    output logic [WORD_W-1:0]             ls_datay,
    output logic [3:0]                    ls_op,
    output logic [TAG_W-1:0]              ls_tagx,
    output logic [TAG_W-1:0]              ls_tagy,
    output logic [TAG_W-1:0]              ls_tagw,
    output logic [4:0]                    ls_waddr,

    output logic [1:0]                    mw_en,
    output logic [1:0][4:0]               mw_addr,
    output logic [1:0][TAG_W-1:0]         mw_tag
);

    localparam int PTR_W = (ALU_CNT > 1) ? $clog2(ALU_CNT) : 1;

    // CLS_NONE covers both NOP and illegal encodings: accepted, never dispatched.
    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_ALU,
        CLS_BR,
        CLS_LS
    } cls_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] datax;
        logic [WORD_W-1:0] datay;
        logic [3:0]        op;
        logic [TAG_W-1:0]  tagx;
        logic [TAG_W-1:0]  tagy;
        logic [TAG_W-1:0]  tagw;
        logic [4:0]        waddr;
    } disp_t;

    function automatic cls_e decode(input logic [7:0] op);
        cls_e c;
        c = CLS_NONE;
        if (op != 8'h00) begin
            case (op[7:4])
                4'b0001, 4'b0010, 4'b0101: c = CLS_ALU;
                4'b0110:                   c = CLS_BR;
                4'b0011, 4'b0100:          c = CLS_LS;
                default:                   c = CLS_NONE;
            endcase
        end
        return c;
    endfunction

    // Rotating ALU index, used by the round-robin search.
    function automatic logic [PTR_W-1:0] wrap(input int v);
        return PTR_W'(v % ALU_CNT);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    disp_t               alu_q [ALU_CNT];
    disp_t               br_q;
    disp_t               ls_q;
    logic [ALU_CNT-1:0]  alu_claim;
    logic                br_claim;
    logic                ls_claim;
    logic [PTR_W-1:0]    rr_ptr;

    // ------------------------------------------------------------------
    // Allocation (combinational)
    // ------------------------------------------------------------------
    logic [ALU_CNT-1:0]  alu_avail;
    logic [ALU_CNT-1:0]  avail1;
    logic                br_avail;
    logic                ls_avail;
    cls_e                cls [2];
    logic [PTR_W-1:0]    alu_idx [2];
    logic [1:0]          alu_found;
    logic [1:0]          ok;
    logic [1:0]          acc;
    logic [1:0]          disp_go;
    logic [1:0]          mw_d;
    logic [TAG_W-1:0]    unit_tag [2];
    disp_t               disp [2];
    logic [PTR_W-1:0]    rr_next;
    int                  start1;

    // A unit dispatched at the last edge has not raised busy yet; the claimed
    // bit masks it for exactly that cycle.
    assign alu_avail = ~alu_busy & ~alu_claim;
    assign br_avail  = !br_busy && !br_claim;
    assign ls_avail  = !ls_busy && !ls_claim;

    always_comb begin
        // NOTE: every variable gets a default before any conditional logic so
        // no path leaves it unassigned and no latch is inferred.
        cls[0]    = decode(in_op[0]);
        cls[1]    = decode(in_op[1]);
        alu_found = '0;
        alu_idx[0] = '0;
        alu_idx[1] = '0;
        ok        = '0;
        acc       = '0;
        disp_go   = '0;
        mw_d      = '0;
        rr_next   = rr_ptr;
        unit_tag[0] = '0;
        unit_tag[1] = '0;

        // Slot 0: first available ALU at or after rr_ptr.
        for (int o = 0; o < ALU_CNT; o++) begin
            if (!alu_found[0] && alu_avail[wrap(int'(rr_ptr) + o)]) begin
                alu_found[0] = 1'b1;
                alu_idx[0]   = wrap(int'(rr_ptr) + o);
            end
        end

        // Slot 1: continue the search after slot 0's grant, without reusing it.
        avail1 = alu_avail;
        start1 = int'(rr_ptr);
        if (cls[0] == CLS_ALU) begin
            avail1[alu_idx[0]] = 1'b0;
            start1             = int'(alu_idx[0]) + 1;
        end
        for (int o = 0; o < ALU_CNT; o++) begin
            if (!alu_found[1] && avail1[wrap(start1 + o)]) begin
                alu_found[1] = 1'b1;
                alu_idx[1]   = wrap(start1 + o);
            end
        end

        case (cls[0])
            CLS_ALU: ok[0] = alu_found[0];
            CLS_BR:  ok[0] = br_avail;
            CLS_LS:  ok[0] = ls_avail;
            default: ok[0] = 1'b1;
        endcase
        // Branch and LS take one instruction per cycle; a second contender waits.
        case (cls[1])
            CLS_ALU: ok[1] = alu_found[1];
            CLS_BR:  ok[1] = br_avail && (cls[0] != CLS_BR);
            CLS_LS:  ok[1] = ls_avail && (cls[0] != CLS_LS);
            default: ok[1] = 1'b1;
        endcase

        acc[0] = rdy && !rst && in_valid[0] && ok[0];
        acc[1] = acc[0] && in_valid[1] && ok[1];

        for (int k = 0; k < 2; k++) begin
            disp_go[k] = acc[k] && (cls[k] != CLS_NONE);
            case (cls[k])
                CLS_ALU: unit_tag[k] = TAG_W'(int'(alu_idx[k]) + 1);
                CLS_BR:  unit_tag[k] = TAG_W'(ALU_CNT + 1);
                CLS_LS:  unit_tag[k] = TAG_W'(ALU_CNT + 2);
                default: unit_tag[k] = '0;
            endcase
            disp[k].pc    = in_pc[k];
            disp[k].datax = in_datax[k];
            disp[k].datay = in_en_ry[k] ? in_datay[k] : '0;
            disp[k].op    = in_op[k][3:0];
            disp[k].tagx  = in_tagx[k];
            disp[k].tagy  = in_en_ry[k] ? in_tagy[k] : '0;
            disp[k].tagw  = unit_tag[k];
            disp[k].waddr = in_waddr[k];
            mw_d[k] = disp_go[k] && in_en_w[k] && (in_waddr[k] != 5'd0);
        end

        // Same destination written twice in one cycle: the younger lock wins.
        if (mw_d[1] && (in_waddr[0] == in_waddr[1]))
            mw_d[0] = 1'b0;

        if (acc[1] && cls[1] == CLS_ALU)
            rr_next = wrap(int'(alu_idx[1]) + 1);
        else if (acc[0] && cls[0] == CLS_ALU)
            rr_next = wrap(int'(alu_idx[0]) + 1);
    end

    assign in_accept = acc;

    // ------------------------------------------------------------------
    // Registered dispatch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload registers are reset as well, because every
            // dispatch field must read as zero after reset, not only the strobes.
            for (int i = 0; i < ALU_CNT; i++)
                alu_q[i] <= '0;
            br_q      <= '0;
            ls_q      <= '0;
            alu_en    <= '0;
            br_en     <= 1'b0;
            ls_en     <= 1'b0;
            alu_claim <= '0;
            br_claim  <= 1'b0;
            ls_claim  <= 1'b0;
            mw_en     <= '0;
            mw_addr   <= '0;
            mw_tag    <= '0;
            rr_ptr    <= '0;
        end else if (rdy) begin
            // NOTE: non-blocking assignments let the per-slot updates below
            // override these defaults while all state changes together at the edge.
            alu_en    <= '0;
            br_en     <= 1'b0;
            ls_en     <= 1'b0;
            alu_claim <= '0;
            br_claim  <= 1'b0;
            ls_claim  <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (disp_go[k]) begin
                    case (cls[k])
                        CLS_ALU: begin
                            alu_q[alu_idx[k]]     <= disp[k];
                            alu_en[alu_idx[k]]    <= 1'b1;
                            alu_claim[alu_idx[k]] <= 1'b1;
                        end
                        CLS_BR: begin
                            br_q     <= disp[k];
                            br_en    <= 1'b1;
                            br_claim <= 1'b1;
                        end
                        CLS_LS: begin
                            ls_q     <= disp[k];
                            ls_en    <= 1'b1;
                            ls_claim <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (mw_d[k]) begin
                    mw_addr[k] <= in_waddr[k];
                    mw_tag[k]  <= unit_tag[k];
                end
            end
            mw_en  <= mw_d;
            rr_ptr <= rr_next;
        end
    end

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    for (genvar i = 0; i < ALU_CNT; i++) begin : g_alu
        assign alu_pc   [i*WORD_W +: WORD_W] = alu_q[i].pc;
        assign alu_datax[i*WORD_W +: WORD_W] = alu_q[i].datax;
        assign alu_datay[i*WORD_W +: WORD_W] = alu_q[i].datay;
        assign alu_op   [i*4      +: 4]      = alu_q[i].op;
        assign alu_tagx [i*TAG_W  +: TAG_W]  = alu_q[i].tagx;
        assign alu_tagy [i*TAG_W  +: TAG_W]  = alu_q[i].tagy;
        assign alu_tagw [i*TAG_W  +: TAG_W]  = alu_q[i].tagw;
        assign alu_waddr[i*5      +: 5]      = alu_q[i].waddr;
    end

    assign br_pc    = br_q.pc;
    assign br_datax = br_q.datax;
    assign br_datay = br_q.datay;
    assign br_op    = br_q.op;
    assign br_tagx  = br_q.tagx;
    assign br_tagy  = br_q.tagy;
    assign br_tagw  = br_q.tagw;
    assign br_waddr = br_q.waddr;

    assign ls_pc    = ls_q.pc;
    assign ls_datax = ls_q.datax;
    assign ls_datay = ls_q.datay;
    assign ls_op    = ls_q.op;
    assign ls_tagx  = ls_q.tagx;
    assign ls_tagy  = ls_q.tagy;
    assign ls_tagw  = ls_q.tagw;
    assign ls_waddr = ls_q.waddr;

endmodule

// File: tb/tb_dispatch_allocator.sv
// -----------------------------------------------------------------------------
// tb_dispatch_allocator
//
// Directed bench for dispatch_allocator with default parameters
// (ALU_CNT=2, TAG_W=4, WORD_W=32). Unit tags are ALU0=1, ALU1=2, BR=3, LS=4.
// Inputs change 1 ns after a rising edge. Registered outputs are read 1 ns
// after the following edge, and in_accept is read before that edge.
// -----------------------------------------------------------------------------
module tb_dispatch_allocator;

    localparam int ALU_CNT = 2;
    localparam int TAG_W   = 4;
    localparam int WORD_W  = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      rdy;
    logic [1:0]                in_valid;
    logic [1:0][WORD_W-1:0]    in_pc;
    logic [1:0][7:0]           in_op;
    logic [1:0]                in_en_ry;
    logic [1:0]                in_en_w;
    logic [1:0][TAG_W-1:0]     in_tagx;
    logic [1:0][TAG_W-1:0]     in_tagy;
    logic [1:0][WORD_W-1:0]    in_datax;
    logic [1:0][WORD_W-1:0]    in_datay;
    logic [1:0][4:0]           in_waddr;
    logic [1:0]                in_accept;
    logic [ALU_CNT-1:0]        alu_busy;
    logic [ALU_CNT-1:0]        alu_en;
    logic [ALU_CNT*WORD_W-1:0] alu_pc, alu_datax, alu_datay;
    logic [ALU_CNT*4-1:0]      alu_op;
    logic [ALU_CNT*TAG_W-1:0]  alu_tagx, alu_tagy, alu_tagw;
    logic [ALU_CNT*5-1:0]      alu_waddr;
    logic                      br_busy, br_en;
    logic [WORD_W-1:0]         br_pc, br_datax, br_datay;
    logic [3:0]                br_op;
    logic [TAG_W-1:0]          br_tagx, br_tagy, br_tagw;
    logic [4:0]                br_waddr;
    logic                      ls_busy, ls_en;
    logic [WORD_W-1:0]         ls_pc, ls_datax, ls_datay;
    logic [3:0]                ls_op;
    logic [TAG_W-1:0]          ls_tagx, ls_tagy, ls_tagw;
    logic [4:0]                ls_waddr;
    logic [1:0]                mw_en;
    logic [1:0][4:0]           mw_addr;
    logic [1:0][TAG_W-1:0]     mw_tag;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dispatch_allocator #(.ALU_CNT(ALU_CNT), .TAG_W(TAG_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_pc(in_pc), .in_op(in_op),
        .in_en_ry(in_en_ry), .in_en_w(in_en_w),
        .in_tagx(in_tagx), .in_tagy(in_tagy),
        .in_datax(in_datax), .in_datay(in_datay),
        .in_waddr(in_waddr), .in_accept(in_accept),
        .alu_busy(alu_busy), .alu_en(alu_en), .alu_pc(alu_pc),
        .alu_datax(alu_datax), .alu_datay(alu_datay), .alu_op(alu_op),
        .alu_tagx(alu_tagx), .alu_tagy(alu_tagy), .alu_tagw(alu_tagw),
        .alu_waddr(alu_waddr),
        .br_busy(br_busy), .br_en(br_en), .br_pc(br_pc),
        .br_datax(br_datax), .br_datay(br_datay), .br_op(br_op),
        .br_tagx(br_tagx), .br_tagy(br_tagy), .br_tagw(br_tagw),
        .br_waddr(br_waddr),
        .ls_busy(ls_busy), .ls_en(ls_en), .ls_pc(ls_pc),
        .ls_datax(ls_datax), .ls_datay(ls_datay), .ls_op(ls_op),
        .ls_tagx(ls_tagx), .ls_tagy(ls_tagy), .ls_tagw(ls_tagw),
        .ls_waddr(ls_waddr),
        .mw_en(mw_en), .mw_addr(mw_addr), .mw_tag(mw_tag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slots();
        in_valid = '0; in_pc = '0; in_op = '0; in_en_ry = '0; in_en_w = '0;
        in_tagx = '0; in_tagy = '0; in_datax = '0; in_datay = '0; in_waddr = '0;
    endtask

    task automatic set_slot(input bit k, input logic [7:0] op, input logic [31:0] pc,
                            input logic en_w, input logic [4:0] waddr);
        in_valid[k] = 1'b1;  in_op[k]    = op;     in_pc[k]    = pc;
        in_en_w[k]  = en_w;  in_waddr[k] = waddr;  in_en_ry[k] = 1'b1;
        in_datax[k] = pc + 32'd1;  in_datay[k] = pc + 32'd2;
        in_tagx[k]  = '0;    in_tagy[k]  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; alu_busy = '0; br_busy = 1'b0; ls_busy = 1'b0;
        clear_slots();
        set_slot(0, 8'h11, 32'h40, 1'b1, 5'd2);
        #1;
        total++; if (in_accept !== 2'b00) $display("FAIL reset_accept: got %b expected 00", in_accept); else passed++;
        tick(); tick();
        total++; if (alu_en !== 2'b00) $display("FAIL reset_alu_en: got %b expected 00", alu_en); else passed++;
        total++; if ({br_en, ls_en, mw_en} !== 4'b0000) $display("FAIL reset_br_ls_mw: got %b expected 0000", {br_en, ls_en, mw_en}); else passed++;
        total++; if (alu_pc !== 64'h0) $display("FAIL reset_alu_pc: got %h expected 0", alu_pc); else passed++;
        rst = 1'b0;
        clear_slots();
    endtask

    task automatic test_dual_alu();
        set_slot(0, 8'h13, 32'h100, 1'b1, 5'd3);
        set_slot(1, 8'h25, 32'h104, 1'b1, 5'd7);
        in_tagy[0] = 4'h9;
        in_tagy[1] = 4'h7; in_en_ry[1] = 1'b0;
        #1;
        total++; if (in_accept !== 2'b11) $display("FAIL dual_accept: got %b expected 11", in_accept); else passed++;
        tick();
        clear_slots();
        total++; if (alu_en !== 2'b11) $display("FAIL dual_alu_en: got %b expected 11", alu_en); else passed++;
        total++; if (alu_tagw !== 8'h21) $display("FAIL dual_tagw: got %h expected 21", alu_tagw); else passed++;
        total++; if (alu_pc !== {32'h104, 32'h100}) $display("FAIL dual_pc: got %h expected %h", alu_pc, {32'h104, 32'h100}); else passed++;
        total++; if (alu_op !== 8'h53) $display("FAIL dual_op: got %h expected 53", alu_op); else passed++;
        total++; if (alu_datay !== {32'h0, 32'h102}) $display("FAIL dual_datay: got %h expected %h", alu_datay, {32'h0, 32'h102}); else passed++;
        total++; if (alu_tagy !== 8'h09) $display("FAIL dual_tagy: got %h expected 09", alu_tagy); else passed++;
        total++; if (mw_en !== 2'b11) $display("FAIL dual_mw_en: got %b expected 11", mw_en); else passed++;
        total++; if (mw_tag !== 8'h21) $display("FAIL dual_mw_tag: got %h expected 21", mw_tag); else passed++;
        total++; if (mw_addr !== {5'd7, 5'd3}) $display("FAIL dual_mw_addr: got %h expected %h", mw_addr, {5'd7, 5'd3}); else passed++;
        tick();
        total++; if (alu_en !== 2'b00) $display("FAIL dual_en_one_cycle: got %b expected 00", alu_en); else passed++;
        total++; if (alu_pc !== {32'h104, 32'h100}) $display("FAIL dual_pc_hold: got %h expected %h", alu_pc, {32'h104, 32'h100}); else passed++;
    endtask

    // rr_ptr is 0 on entry; claimed bits are clear.
    task automatic test_busy_claim();
        alu_busy = 2'b01;
        set_slot(0, 8'h11, 32'h200, 1'b0, 5'd0);
        set_slot(1, 8'h12, 32'h204, 1'b0, 5'd0);
        #1;
        total++; if (in_accept !== 2'b01) $display("FAIL busy_accept: got %b expected 01", in_accept); else passed++;
        tick();
        total++; if (alu_en !== 2'b10) $display("FAIL busy_alu_en: got %b expected 10", alu_en); else passed++;
        total++; if (alu_tagw[7:4] !== 4'h2) $display("FAIL busy_tagw: got %h expected 2", alu_tagw[7:4]); else passed++;
        // ALU1 is now claimed even though busy has dropped.
        alu_busy = 2'b00;
        set_slot(0, 8'h12, 32'h204, 1'b0, 5'd0);
        set_slot(1, 8'h13, 32'h208, 1'b0, 5'd0);
        #1;
        total++; if (in_accept !== 2'b01) $display("FAIL claim_accept: got %b expected 01", in_accept); else passed++;
        tick();
        total++; if (alu_en !== 2'b01) $display("FAIL claim_alu_en: got %b expected 01", alu_en); else passed++;
        total++; if (alu_pc[31:0] !== 32'h204) $display("FAIL claim_pc: got %h expected 204", alu_pc[31:0]); else passed++;
        // rr_ptr is 1 and ALU0 is claimed: slot 0 lands on ALU1.
        set_slot(0, 8'h13, 32'h208, 1'b0, 5'd0);
        set_slot(1, 8'h14, 32'h20C, 1'b0, 5'd0);
        #1;
        total++; if (in_accept !== 2'b01) $display("FAIL rr_accept: got %b expected 01", in_accept); else passed++;
        tick();
        clear_slots();
        total++; if (alu_en !== 2'b10) $display("FAIL rr_alu_en: got %b expected 10", alu_en); else passed++;
        total++; if (alu_pc[63:32] !== 32'h208) $display("FAIL rr_pc: got %h expected 208", alu_pc[63:32]); else passed++;
        tick();
    endtask

    task automatic test_back_to_back_branch();
        set_slot(0, 8'h61, 32'h300, 1'b0, 5'd0);
        set_slot(1, 8'h62, 32'h304, 1'b0, 5'd0);
        #1;
        total++; if (in_accept !== 2'b01) $display("FAIL br_accept: got %b expected 01", in_accept); else passed++;
        tick();
        clear_slots();
        set_slot(0, 8'h62, 32'h304, 1'b0, 5'd0);
        total++; if (br_en !== 1'b1) $display("FAIL br_en: got %b expected 1", br_en); else passed++;
        total++; if ({br_pc, br_tagw} !== {32'h300, 4'h3}) $display("FAIL br_fields: got %h expected %h", {br_pc, br_tagw}, {32'h300, 4'h3}); else passed++;
        total++; if (in_accept !== 2'b00) $display("FAIL br_claimed_accept: got %b expected 00", in_accept); else passed++;
        tick();
        total++; if (br_en !== 1'b0) $display("FAIL br_en_one_cycle: got %b expected 0", br_en); else passed++;
        total++; if (in_accept !== 2'b01) $display("FAIL br_second_accept: got %b expected 01", in_accept); else passed++;
        tick();
        clear_slots();
        total++; if ({br_en, br_pc} !== {1'b1, 32'h304}) $display("FAIL br_second: got %h expected %h", {br_en, br_pc}, {1'b1, 32'h304}); else passed++;
        tick();
    endtask

    // rr_ptr is 0 on entry.
    task automatic test_mw_update();
        set_slot(0, 8'h11, 32'h380, 1'b1, 5'd5);
        set_slot(1, 8'h12, 32'h384, 1'b1, 5'd5);
        #1;
        total++; if (in_accept !== 2'b11) $display("FAIL mw_same_accept: got %b expected 11", in_accept); else passed++;
        tick();
        clear_slots();
        total++; if (mw_en !== 2'b10) $display("FAIL mw_same_en: got %b expected 10", mw_en); else passed++;
        total++; if ({mw_addr[1], mw_tag[1]} !== {5'd5, 4'h2}) $display("FAIL mw_same_fields: got %h expected %h", {mw_addr[1], mw_tag[1]}, {5'd5, 4'h2}); else passed++;
        tick();
        set_slot(0, 8'h11, 32'h390, 1'b1, 5'd0);
        set_slot(1, 8'h12, 32'h394, 1'b1, 5'd0);
        tick();
        clear_slots();
        total++; if ({alu_en, mw_en} !== 4'b1100) $display("FAIL mw_r0: got %b expected 1100", {alu_en, mw_en}); else passed++;
        tick();
        // NOP and illegal: accepted, nothing dispatched, no lock update.
        set_slot(0, 8'h00, 32'h3A0, 1'b1, 5'd9);
        set_slot(1, 8'hF3, 32'h3A4, 1'b1, 5'd9);
        #1;
        total++; if (in_accept !== 2'b11) $display("FAIL nop_accept: got %b expected 11", in_accept); else passed++;
        tick();
        total++; if ({alu_en, br_en, ls_en, mw_en} !== 6'b0) $display("FAIL nop_dispatch: got %b expected 000000", {alu_en, br_en, ls_en, mw_en}); else passed++;
        // Two LS ops: only slot 0 goes.
        set_slot(0, 8'h31, 32'h400, 1'b1, 5'd9);
        set_slot(1, 8'h41, 32'h404, 1'b1, 5'd10);
        #1;
        total++; if (in_accept !== 2'b01) $display("FAIL ls_accept: got %b expected 01", in_accept); else passed++;
        tick();
        clear_slots();
        total++; if ({ls_en, ls_tagw, ls_pc} !== {1'b1, 4'h4, 32'h400}) $display("FAIL ls_fields: got %h expected %h", {ls_en, ls_tagw, ls_pc}, {1'b1, 4'h4, 32'h400}); else passed++;
        total++; if ({mw_en, mw_tag[0]} !== {2'b01, 4'h4}) $display("FAIL ls_mw: got %h expected %h", {mw_en, mw_tag[0]}, {2'b01, 4'h4}); else passed++;
        tick();
    endtask

    // rr_ptr is 0 on entry.
    task automatic test_stall_reset();
        set_slot(0, 8'h14, 32'h500, 1'b0, 5'd0);
        tick();
        total++; if ({alu_en, alu_pc[31:0]} !== {2'b01, 32'h500}) $display("FAIL stall_setup: got %h expected %h", {alu_en, alu_pc[31:0]}, {2'b01, 32'h500}); else passed++;
        rdy = 1'b0;
        set_slot(0, 8'h15, 32'h504, 1'b1, 5'd4);
        set_slot(1, 8'h16, 32'h508, 1'b1, 5'd6);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (in_accept !== 2'b00) $display("FAIL stall_accept_%0d: got %b expected 00", c, in_accept); else passed++;
            tick();
            total++; if ({alu_en, alu_pc[31:0], mw_en} !== {2'b01, 32'h500, 2'b00}) $display("FAIL stall_frozen_%0d: got %h expected %h", c, {alu_en, alu_pc[31:0], mw_en}, {2'b01, 32'h500, 2'b00}); else passed++;
        end
        rst = 1'b1;
        #1;
        total++; if (in_accept !== 2'b00) $display("FAIL rst_stall_accept: got %b expected 00", in_accept); else passed++;
        tick();
        total++; if ({alu_en, alu_pc, mw_en, br_en, ls_en} !== '0) $display("FAIL rst_stall_clear: got %h expected 0", {alu_en, alu_pc, mw_en, br_en, ls_en}); else passed++;
        rst = 1'b0; rdy = 1'b1;
        clear_slots();
        tick();
        total++; if (alu_en !== 2'b00) $display("FAIL rst_no_strobe: got %b expected 00", alu_en); else passed++;
        // rr_ptr was 1 before reset; after reset the search starts at ALU0.
        set_slot(0, 8'h17, 32'h600, 1'b0, 5'd0);
        tick();
        clear_slots();
        total++; if (alu_en !== 2'b01) $display("FAIL rst_rr_ptr: got %b expected 01", alu_en); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_dual_alu();
        test_busy_claim();
        test_back_to_back_branch();
        test_mw_update();
        test_stall_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
